// File: rtl/ea_pkg.sv
// ea_pkg: shared constants and FSM state type for the EA4163 input scan sequencer
package ea_pkg;
  localparam int NCH = 24;
  localparam int NGRP = 3;
  localparam int MUXW = 3;
  localparam int NPOS = 8;
  localparam int SETTLE_CYC_DEF = 32;
  typedef enum logic [2:0] {IDLE, SETUP, SETTLE, SAMPLE, COMMIT} state_e;
endpackage

// File: rtl/ea_inscan_if.sv
// ea_inscan_if: register-file and input-multiplexer bus of the scan sequencer
interface ea_inscan_if;
  import ea_pkg::*;
  logic I_SCAN_EN;
  logic I_M_1_8_IN;
  logic I_M_9_16_IN;
  logic I_M_17_24_IN;
  logic [NCH-1:0] I_BLCKIN;
  logic [NCH-1:0] I_INTMSK;
  logic [NCH-1:0] I_CHG_CLR;
  logic [MUXW-1:0] O_MUX_A;
  logic O_MUX_1_8_EN;
  logic O_MUX_9_16_EN;
  logic O_MUX_17_24_EN;
  logic [NCH-1:0] O_DATAIN;
  logic [NCH-1:0] O_CHG;
  logic O_FRAME_DONE;
  logic O_IRQ_REQ;
  modport slave (
    input  I_SCAN_EN, I_M_1_8_IN, I_M_9_16_IN, I_M_17_24_IN, I_BLCKIN, I_INTMSK, I_CHG_CLR,
    output O_MUX_A, O_MUX_1_8_EN, O_MUX_9_16_EN, O_MUX_17_24_EN, O_DATAIN, O_CHG,
           O_FRAME_DONE, O_IRQ_REQ
  );
  modport master (
    output I_SCAN_EN, I_M_1_8_IN, I_M_9_16_IN, I_M_17_24_IN, I_BLCKIN, I_INTMSK, I_CHG_CLR,
    input  O_MUX_A, O_MUX_1_8_EN, O_MUX_9_16_EN, O_MUX_17_24_EN, O_DATAIN, O_CHG,
           O_FRAME_DONE, O_IRQ_REQ
  );
endinterface

// File: rtl/ea_sync2.sv
// ea_sync2: two-flop synchroniser for one asynchronous multiplexer output, resets to 0
module ea_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  // shift the raw input through two flops before anyone looks at it
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      meta_q <= 1'b0;
      q_o <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o <= meta_q;
    end
endmodule

// File: rtl/ea_inscan.sv
// ea_inscan: walks the 3-bit mux address, samples 3 mux outputs into a 24-bit snapshot with blocking and sticky change flags
// Define EA_INSCAN_DEBOUNCE_EN to commit a channel only when two consecutive frames agree.
module ea_inscan
  import ea_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input logic I_CLK_32M,
  input logic I_RESET_N,
  ea_inscan_if.slave bus
);
  state_e state_q, state_d;
  logic [MUXW-1:0] addr_q, addr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [NCH-1:0] shadow_q, shadow_d;
  logic [NCH-1:0] datain_q, datain_d;
  logic [NCH-1:0] chg_q, chg_d;
  logic [NCH-1:0] new_v, commit_v;
  logic done_q, commit, scanning;
  logic [NGRP-1:0] m_raw, m_sync;
  assign m_raw = {bus.I_M_17_24_IN, bus.I_M_9_16_IN, bus.I_M_1_8_IN};
  for (genvar g = 0; g < NGRP; g++) begin : g_sync
    ea_sync2 u_sync (.clk_i(I_CLK_32M), .rst_ni(I_RESET_N), .d_i(m_raw[g]), .q_o(m_sync[g]));
  end
  assign commit = state_q == COMMIT;
  assign scanning = state_q inside {SETUP, SETTLE, SAMPLE};
  // next state: address walk and settle countdown; losing scan enable mid-frame aborts to idle
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (bus.I_SCAN_EN) begin
        state_d = SETUP;
        addr_d = '0;
      end
      SETUP: begin
        cnt_d = 8'(SETTLE_CYC - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = cnt_q == 8'd0 ? SAMPLE : SETTLE;
        cnt_d = cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
      end
      SAMPLE: begin
        state_d = addr_q == MUXW'(NPOS - 1) ? COMMIT : SETUP;
        addr_d = addr_q == MUXW'(NPOS - 1) ? addr_q : addr_q + 1'b1;
      end
      COMMIT: begin
        state_d = bus.I_SCAN_EN ? SETUP : IDLE;
        addr_d = '0;
      end
      default: state_d = IDLE;
    endcase
    if (scanning && !bus.I_SCAN_EN) begin
      state_d = IDLE;
      addr_d = '0;
    end
  end
  // capture one bit of each channel group at the current address
  always_comb begin
    shadow_d = shadow_q;
    if (state_q == SAMPLE) begin
      shadow_d[{2'd0, addr_q}] = m_sync[0];
      shadow_d[{2'd1, addr_q}] = m_sync[1];
      shadow_d[{2'd2, addr_q}] = m_sync[2];
    end
  end
  assign new_v = shadow_q & bus.I_BLCKIN;
`ifdef EA_INSCAN_DEBOUNCE_EN
  logic [NCH-1:0] prev_q;
  logic [NCH-1:0] agree;
  assign agree = ~(new_v ^ prev_q);
  assign commit_v = ((new_v & agree) | (datain_q & ~agree)) & bus.I_BLCKIN;
  // remember last frame's raw blocked snapshot so the next frame can confirm it
  always_ff @(posedge I_CLK_32M or negedge I_RESET_N)
    if (!I_RESET_N) prev_q <= '0;
    else if (commit) prev_q <= new_v;
`else
  assign commit_v = new_v;
`endif
  // commit the snapshot; clears apply every cycle but a same-cycle change still sets the flag
  always_comb begin
    datain_d = commit ? commit_v : datain_q;
    chg_d = (chg_q & ~bus.I_CHG_CLR) | (commit ? (commit_v ^ datain_q) & bus.I_BLCKIN : '0);
  end
  // state and datapath registers
  always_ff @(posedge I_CLK_32M or negedge I_RESET_N)
    if (!I_RESET_N) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      shadow_q <= '0;
      datain_q <= '0;
      chg_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      datain_q <= datain_d;
      chg_q <= chg_d;
      done_q <= commit;
    end
  assign bus.O_MUX_A = scanning ? addr_q : '0;
  assign bus.O_MUX_1_8_EN = scanning;
  assign bus.O_MUX_9_16_EN = scanning;
  assign bus.O_MUX_17_24_EN = scanning;
  assign bus.O_DATAIN = datain_q;
  assign bus.O_CHG = chg_q;
  assign bus.O_FRAME_DONE = done_q;
  assign bus.O_IRQ_REQ = |(chg_q & bus.I_INTMSK);
endmodule
